// File: rtl/uart_sram_loader.sv
// UART command-frame loader: parses 'W'/'R' frames and drives a
// 64-bit SRAM port, answering with ACK/NAK bytes or read data.
module uart_sram_loader #(
  parameter int          LEN_ADDR       = 64,
  parameter int          TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  ACK_BYTE       = 8'h4B,
  parameter logic [7:0]  NAK_BYTE       = 8'h3F
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_ready,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic [LEN_ADDR-1:0] addra,
  output logic [63:0]         dina,
  input  logic [63:0]         douta,
  output logic                ena,
  output logic [7:0]          wea,
  output logic                busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;

  typedef enum logic [3:0] {
    IDLE, ADDR, DATA, WR, ACK,
    NAK, RD_REQ, RD_WAIT, TX
  } state_t;

  state_t        state, nxt;
  logic          op_wr;
  logic [2:0]    cnt;
  logic [31:0]   addr_q;
  logic [63:0]   shreg;
  logic [TW-1:0] tmo;
  logic          tmo_hit;
  logic          in_frame;

  assign addra    = LEN_ADDR'({addr_q[31:3], 3'b000});
  assign in_frame = (state == ADDR) || (state == DATA);
  assign tmo_hit  = !rx_ready && (tmo == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    nxt      = state;
    ena      = 1'b0;
    wea      = 8'h00;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (rx_ready) begin
          if (rx_data == CMD_W || rx_data == CMD_R) nxt = ADDR;
          else nxt = NAK;
        end
      end
      ADDR: begin
        if (rx_ready && cnt == 3'd3) nxt = op_wr ? DATA : RD_REQ;
        else if (tmo_hit) nxt = IDLE;
      end
      DATA: begin
        if (rx_ready && cnt == 3'd7) nxt = WR;
        else if (tmo_hit) nxt = IDLE;
      end
      WR: begin
        ena = 1'b1;
        wea = 8'hFF;
        nxt = ACK;
      end
      ACK: begin
        tx_valid = 1'b1;
        tx_data  = ACK_BYTE;
        if (tx_ready) nxt = IDLE;
      end
      NAK: begin
        tx_valid = 1'b1;
        tx_data  = NAK_BYTE;
        if (tx_ready) nxt = IDLE;
      end
      RD_REQ: begin
        ena = 1'b1;
        nxt = RD_WAIT;
      end
      RD_WAIT: nxt = TX;
      TX: begin
        tx_valid = 1'b1;
        tx_data  = shreg[7:0];
        if (tx_ready && cnt == 3'd7) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_wr  <= 1'b0;
      cnt    <= '0;
      addr_q <= '0;
      dina   <= '0;
      shreg  <= '0;
      tmo    <= '0;
    end else begin
      state <= nxt;
      if (in_frame && !rx_ready) tmo <= tmo + 1'b1;
      else tmo <= '0;
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_ready) op_wr <= (rx_data == CMD_W);
        end
        ADDR: begin
          if (rx_ready) begin
            addr_q <= {rx_data, addr_q[31:8]};
            cnt    <= (cnt == 3'd3) ? 3'd0 : cnt + 3'd1;
          end
        end
        DATA: begin
          if (rx_ready) begin
            dina <= {rx_data, dina[63:8]};
            cnt  <= cnt + 3'd1;
          end
        end
        RD_WAIT: begin
          shreg <= douta;
          cnt   <= '0;
        end
        TX: begin
          // cnt wraps to 0 on the 8th handshake
          if (tx_ready) begin
            shreg <= {8'h00, shreg[63:8]};
            cnt   <= cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sram_loader.sv
// Randomized bench for uart_sram_loader with an SRAM model,
// tx/ena protocol monitor and a frame-level reference memory.
module tb_uart_sram_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [63:0] addra;
  logic [63:0] dina;
  logic [63:0] douta = 64'h0;
  logic        ena;
  logic [7:0]  wea;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  uart_sram_loader #(
    .LEN_ADDR(64), .TIMEOUT_CYCLES(16),
    .ACK_BYTE(8'h4B), .NAK_BYTE(8'h3F)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .addra(addra), .dina(dina), .douta(douta),
    .ena(ena), .wea(wea), .busy(busy)
  );

  logic [63:0] mem [logic [63:0]];
  logic [63:0] exp_mem [logic [63:0]];
  logic [7:0]  txq [$];
  logic [63:0] acc_a [$];
  logic [63:0] acc_d [$];
  logic [7:0]  acc_w [$];
  bit          bp_rand = 0;
  int          hold_idx = -1;
  int          hold_left = 0;
  bit          pend = 0;
  bit          prev_ena = 0;
  logic [7:0]  pend_data = 8'h00;

  // SRAM environment: 1-cycle read latency
  always @(posedge clk) begin
    if (ena) begin
      douta <= mem.exists(addra) ? mem[addra] : 64'h0;
      if (wea == 8'hFF) mem[addra] = dina;
    end
  end

  // tx sink with backpressure plus ena/wea protocol checks
  always @(negedge clk) begin
    if (hold_left > 0 && tx_valid && txq.size() == hold_idx) begin
      tx_ready = 1'b0;
      hold_left--;
    end else if (bp_rand) begin
      tx_ready = ($urandom_range(0, 2) != 0);
    end else begin
      tx_ready = 1'b1;
    end
    if (rst) pend = 0;
    if (pend) begin
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== pend_data) begin
        errors++;
        $display("FAIL tx_stable: got v=%b d=%h need v=1 d=%h",
                 tx_valid, tx_data, pend_data);
      end
    end
    if (tx_valid && tx_ready) txq.push_back(tx_data);
    pend      = tx_valid && !tx_ready;
    pend_data = tx_data;
    if (ena) begin
      vectors++;
      if (prev_ena) begin
        errors++;
        $display("FAIL ena_pulse: ena high two cycles, need one");
      end
      acc_a.push_back(addra);
      acc_d.push_back(dina);
      acc_w.push_back(wea);
    end else if (wea !== 8'h00) begin
      errors++;
      $display("FAIL wea_idle: wea=%h with ena=0, need 00", wea);
    end
    prev_ena = ena;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors + 1);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] key(input logic [31:0] a);
    return {32'h0, a[31:3], 3'b000};
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_frame(input logic [7:0] fb[$], input int maxgap);
    foreach (fb[i]) send_byte(fb[i], $urandom_range(0, maxgap));
  endtask

  task automatic wait_idle(input int maxc);
    int c = 0;
    while (busy !== 1'b0 && c < maxc) begin
      @(negedge clk);
      c++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_wait: busy=%b after %0d cycles, need 0",
               busy, maxc);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [63:0] d,
                          input int maxgap);
    logic [7:0] fb[$];
    int n0;
    n0 = acc_a.size();
    txq.delete();
    fb = {8'h57};
    for (int i = 0; i < 4; i++) fb.push_back(a[8*i +: 8]);
    for (int i = 0; i < 8; i++) fb.push_back(d[8*i +: 8]);
    send_frame(fb, maxgap);
    vectors++;
    if (ena !== 1'b1 || wea !== 8'hFF || addra !== key(a)
        || dina !== d) begin
      errors++;
      $display("FAIL wr_strobe: ena=%b wea=%h a=%h d=%h need 1 FF %h %h",
               ena, wea, addra, dina, key(a), d);
    end
    @(negedge clk);
    vectors++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h4B) begin
      errors++;
      $display("FAIL wr_ack: v=%b d=%h need 1 4b", tx_valid, tx_data);
    end
    wait_idle(200);
    exp_mem[key(a)] = d;
    vectors++;
    if (acc_a.size() != n0 + 1) begin
      errors++;
      $display("FAIL wr_count: %0d accesses, need 1", acc_a.size() - n0);
    end else if (acc_w[n0] !== 8'hFF || acc_a[n0] !== key(a)
                 || acc_d[n0] !== d) begin
      errors++;
      $display("FAIL wr_access: %h %h %h need ff %h %h",
               acc_w[n0], acc_a[n0], acc_d[n0], key(a), d);
    end
    vectors++;
    if (txq.size() != 1 || txq[0] !== 8'h4B) begin
      errors++;
      $display("FAIL wr_txq: %0d bytes, need one 4b", txq.size());
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int maxgap,
                         input bit inject);
    logic [7:0] fb[$];
    logic [63:0] e;
    int n0;
    e  = exp_mem.exists(key(a)) ? exp_mem[key(a)] : 64'h0;
    n0 = acc_a.size();
    txq.delete();
    fb = {8'h52};
    for (int i = 0; i < 4; i++) fb.push_back(a[8*i +: 8]);
    send_frame(fb, maxgap);
    vectors++;
    if (ena !== 1'b1 || wea !== 8'h00 || addra !== key(a)) begin
      errors++;
      $display("FAIL rd_strobe: ena=%b wea=%h a=%h need 1 00 %h",
               ena, wea, addra, key(a));
    end
    @(negedge clk);
    vectors++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_lat: tx_valid=%b one cycle after ena, need 0",
               tx_valid);
    end
    @(negedge clk);
    vectors++;
    if (tx_valid !== 1'b1 || tx_data !== e[7:0]) begin
      errors++;
      $display("FAIL rd_first: v=%b d=%h need 1 %h",
               tx_valid, tx_data, e[7:0]);
    end
    if (inject) begin
      int c = 0;
      #1;
      while (txq.size() < 1 && c < 50) begin
        @(negedge clk);
        #1;
        c++;
      end
      for (int k = 0; k < 2; k++) begin
        send_byte(8'h57, 0);
        #1;
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== e[15:8]) begin
          errors++;
          $display("FAIL bp_hold: v=%b d=%h need 1 %h",
                   tx_valid, tx_data, e[15:8]);
        end
      end
    end
    wait_idle(400);
    vectors++;
    if (acc_a.size() != n0 + 1) begin
      errors++;
      $display("FAIL rd_count: %0d accesses, need 1", acc_a.size() - n0);
    end else if (acc_w[n0] !== 8'h00 || acc_a[n0] !== key(a)) begin
      errors++;
      $display("FAIL rd_access: wea=%h a=%h need 00 %h",
               acc_w[n0], acc_a[n0], key(a));
    end
    vectors++;
    if (txq.size() != 8) begin
      errors++;
      $display("FAIL rd_len: %0d bytes, need 8", txq.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (txq[i] !== e[8*i +: 8]) begin
          errors++;
          $display("FAIL rd_byte%0d: got %h need %h",
                   i, txq[i], e[8*i +: 8]);
        end
      end
    end
  endtask

  task automatic do_nak(input logic [7:0] b);
    int n0;
    n0 = acc_a.size();
    txq.delete();
    send_byte(b, 0);
    vectors++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h3F || ena !== 1'b0) begin
      errors++;
      $display("FAIL nak: v=%b d=%h ena=%b need 1 3f 0",
               tx_valid, tx_data, ena);
    end
    wait_idle(200);
    vectors++;
    if (txq.size() != 1 || txq[0] !== 8'h3F || acc_a.size() != n0) begin
      errors++;
      $display("FAIL nak_txq: %0d bytes, %0d accesses, need one 3f, 0",
               txq.size(), acc_a.size() - n0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (tx_valid !== 0 || tx_data !== 0 || ena !== 0 || wea !== 0
        || addra !== 0 || dina !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL reset: v=%b d=%h e=%b w=%h a=%h di=%h b=%b need 0",
               tx_valid, tx_data, ena, wea, addra, dina, busy);
    end
    #2 rst = 1'b0;
  endtask

  task automatic test_write_read_fixed();
    do_write(32'h6000_0010, 64'h0123_4567_89AB_CDEF, 0);
    do_write(32'h6000_0008, 64'h1122_3344_5566_7788, 0);
    do_read(32'h6000_000C, 0, 0);
  endtask

  task automatic test_nak();
    do_nak(8'h41);
    do_read(32'h6000_0013, 1, 0);
  endtask

  task automatic test_timeout();
    int n0;
    n0 = acc_a.size();
    txq.delete();
    send_byte(8'h57, 0);
    send_byte(8'h10, 0);
    repeat (15) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early: busy=%b at 15 idle cycles, need 1", busy);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_expire: busy=%b at 16 idle cycles, need 0", busy);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (txq.size() != 0 || acc_a.size() != n0) begin
      errors++;
      $display("FAIL tmo_silent: %0d tx, %0d accesses, need 0 0",
               txq.size(), acc_a.size() - n0);
    end
    do_write(32'h6000_0020, 64'hDEAD_BEEF_CAFE_F00D, 0);
  endtask

  task automatic test_backpressure();
    bp_rand   = 0;
    hold_idx  = 1;
    hold_left = 5;
    do_read(32'h6000_0008, 0, 1);
    hold_idx  = -1;
    hold_left = 0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] fb[$];
    int n0;
    int c;
    n0 = acc_a.size();
    fb = {8'h57, 8'h40, 8'h00, 8'h00, 8'h60, 8'hAA};
    send_frame(fb, 0);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 0 || tx_valid !== 0 || ena !== 0) begin
      errors++;
      $display("FAIL rst_mid: busy=%b v=%b ena=%b need 0 0 0",
               busy, tx_valid, ena);
    end
    #2 rst = 1'b0;
    repeat (30) @(negedge clk);
    vectors++;
    if (acc_a.size() != n0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_nowrite: %0d accesses busy=%b need 0 0",
               acc_a.size() - n0, busy);
    end
    fb = {8'h52, 8'h10, 8'h00, 8'h00, 8'h60};
    send_frame(fb, 0);
    c = 0;
    while (tx_valid !== 1'b1 && c < 20) begin
      @(negedge clk);
      c++;
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (tx_valid !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL rst_tx: v=%b busy=%b need 0 0", tx_valid, busy);
    end
    #2 rst = 1'b0;
    do_read(32'h6000_0010, 0, 0);
  endtask

  task automatic test_random();
    logic [31:0] addrs[$];
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  b;
    bp_rand = 1;
    for (int n = 0; n < 10; n++) begin
      a = $urandom;
      d = {$urandom, $urandom};
      do_write(a, d, 3);
      addrs.push_back(a);
      if ($urandom_range(0, 2) == 0) begin
        b = 8'($urandom);
        while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
        do_nak(b);
      end
    end
    do_write(addrs[0], {$urandom, $urandom}, 2);
    foreach (addrs[i]) begin
      a = {addrs[i][31:3], 3'($urandom)};
      do_read(a, 3, 0);
    end
    do_read($urandom, 2, 0);
    bp_rand = 0;
  endtask

  initial begin
    test_reset();
    test_write_read_fixed();
    test_nak();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_random();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
